// File: rtl/serial_receiver.sv
// Reassembles MSB-first SIZE-bit chunks into DinLENGTH-bit words; optional idle-gap abort via RX_TIMEOUT_EN.
// Latency: DataValid rises on the edge that samples the last chunk.
// Backpressure: one-deep holding register; a word completing while it is full and not drained is dropped (sticky Overrun).
module serial_receiver #(
    parameter int DinLENGTH = 32,
    parameter int SIZE      = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic [SIZE-1:0]      DataIn,
    input  logic                 ChunkValid,
    input  logic                 FrameStart,
    input  logic                 DataReady,
    input  logic                 ClearStatus,
    output logic [DinLENGTH-1:0] DataOut,
    output logic                 DataValid,
    output logic                 RxBusy,
    output logic                 Overrun,
    output logic                 FrameError
);

    localparam int CHUNKS = DinLENGTH / SIZE;
    localparam int CNTW   = $clog2(CHUNKS) + 1;
    localparam logic [CNTW-1:0] LASTCNT = CNTW'(CHUNKS - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    generate
        if ((DinLENGTH % SIZE) != 0 || TIMEOUT < 1) begin : gBadParams
            $error("serial_receiver: DinLENGTH must be a multiple of SIZE and TIMEOUT >= 1");
        end
    endgenerate

    logic [0:0]           state;
    logic [DinLENGTH-1:0] shiftReg;
    logic [DinLENGTH-1:0] shiftedWord;
    logic [DinLENGTH-1:0] newWord;
    logic [CNTW-1:0]      chunkCnt;
    logic                 wordDone;
    logic                 canLoad;
    logic                 timeoutHit;

    always_comb begin
        shiftedWord = (shiftReg << SIZE) | DinLENGTH'(DataIn);
        newWord     = (state == IDLE) ? DinLENGTH'(DataIn) : shiftedWord;
        wordDone    = ChunkValid &&
                      (((state == IDLE) && FrameStart && (CHUNKS == 1)) ||
                       ((state == COLLECT) && !FrameStart && (chunkCnt == LASTCNT)));
        // Holding register can take a word if empty or being drained this cycle.
        canLoad     = !DataValid || DataReady;
    end

    assign RxBusy = (state == COLLECT);

`ifdef RX_TIMEOUT_EN
    localparam int GAPW = $clog2(TIMEOUT + 1);
    localparam logic [GAPW-1:0] GAPLAST = GAPW'(TIMEOUT - 1);

    logic [GAPW-1:0] gapCnt;

    assign timeoutHit = (state == COLLECT) && !ChunkValid && (gapCnt == GAPLAST);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            gapCnt <= '0;
        end else if ((state != COLLECT) || ChunkValid || timeoutHit) begin
            gapCnt <= '0;
        end else begin
            gapCnt <= gapCnt + GAPW'(1);
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= IDLE;
            shiftReg   <= '0;
            chunkCnt   <= '0;
            FrameError <= 1'b0;
        end else begin
            FrameError <= 1'b0;
            case (state)
                IDLE: begin
                    if (ChunkValid) begin
                        if (FrameStart) begin
                            shiftReg <= DinLENGTH'(DataIn);
                            if (CHUNKS == 1) begin
                                chunkCnt <= '0;
                            end else begin
                                chunkCnt <= CNTW'(1);
                                state    <= COLLECT;
                            end
                        end else begin
                            FrameError <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (ChunkValid) begin
                        if (FrameStart) begin
                            // Restart: the interrupting chunk becomes chunk 1 of a new word.
                            FrameError <= 1'b1;
                            shiftReg   <= DinLENGTH'(DataIn);
                            chunkCnt   <= CNTW'(1);
                        end else begin
                            shiftReg <= shiftedWord;
                            if (chunkCnt == LASTCNT) begin
                                chunkCnt <= '0;
                                state    <= IDLE;
                            end else begin
                                chunkCnt <= chunkCnt + CNTW'(1);
                            end
                        end
                    end else if (timeoutHit) begin
                        FrameError <= 1'b1;
                        shiftReg   <= '0;
                        chunkCnt   <= '0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            if (wordDone && canLoad) begin
                DataOut   <= newWord;
                DataValid <= 1'b1;
            end else if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end
            // A fresh overrun takes priority over ClearStatus.
            if (wordDone && !canLoad) begin
                Overrun <= 1'b1;
            end else if (ClearStatus) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver (DinLENGTH=32, SIZE=4, TIMEOUT=16); one task per scenario.
module tb_serial_receiver;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [3:0]  DataIn;
    logic        ChunkValid;
    logic        FrameStart;
    logic        DataReady;
    logic        ClearStatus;
    logic [31:0] DataOut;
    logic        DataValid;
    logic        RxBusy;
    logic        Overrun;
    logic        FrameError;

    int vecs = 0;
    int errs = 0;

    serial_receiver #(.DinLENGTH(32), .SIZE(4), .TIMEOUT(16)) dut (
        .Clk(Clk), .ResetN(ResetN), .DataIn(DataIn), .ChunkValid(ChunkValid),
        .FrameStart(FrameStart), .DataReady(DataReady), .ClearStatus(ClearStatus),
        .DataOut(DataOut), .DataValid(DataValid), .RxBusy(RxBusy),
        .Overrun(Overrun), .FrameError(FrameError)
    );

    always #5 Clk = ~Clk;

    // Present one chunk for one edge; returns 1 time unit after that edge.
    task automatic chunk(input logic [3:0] d, input logic fs);
        DataIn = d; ChunkValid = 1'b1; FrameStart = fs;
        @(posedge Clk); #1;
        ChunkValid = 1'b0; FrameStart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic send_chunks(input logic [31:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) chunk(w[31-4*i -: 4], i == 0);
    endtask

    task automatic test_reset;
        ResetN = 1'b0; DataIn = 4'h0; ChunkValid = 1'b0; FrameStart = 1'b0;
        DataReady = 1'b1; ClearStatus = 1'b0;
        #12;
        vecs++; if (DataOut !== 32'h0) begin errs++; $display("FAIL reset_dataout got %h want %h", DataOut, 32'h0); end
        vecs++; if ({DataValid, RxBusy, Overrun, FrameError} !== 4'b0000) begin errs++; $display("FAIL reset_flags got %b want 0000", {DataValid, RxBusy, Overrun, FrameError}); end
        ResetN = 1'b1;
        idle(1);
    endtask

    task automatic test_nominal;
        logic [31:0] w;
        w = 32'hDEADBEEF;
        DataReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chunk(w[31-4*i -: 4], i == 0);
            vecs++; if (RxBusy !== 1'b1) begin errs++; $display("FAIL nominal_busy chunk %0d got %b want 1", i, RxBusy); end
            vecs++; if (DataValid !== 1'b0) begin errs++; $display("FAIL nominal_early_valid chunk %0d got %b want 0", i, DataValid); end
        end
        chunk(w[3:0], 1'b0);
        vecs++; if (DataOut !== 32'hDEADBEEF) begin errs++; $display("FAIL nominal_data got %h want %h", DataOut, 32'hDEADBEEF); end
        vecs++; if ({DataValid, RxBusy, Overrun, FrameError} !== 4'b1000) begin errs++; $display("FAIL nominal_flags got %b want 1000", {DataValid, RxBusy, Overrun, FrameError}); end
        idle(1);
        vecs++; if (DataValid !== 1'b0) begin errs++; $display("FAIL nominal_consumed got %b want 0", DataValid); end
    endtask

    task automatic test_overrun;
        DataReady = 1'b0;
        send_chunks(32'h12345678, 0, 7);
        vecs++; if (DataValid !== 1'b1 || DataOut !== 32'h12345678) begin errs++; $display("FAIL ovr_first got %b/%h want 1/%h", DataValid, DataOut, 32'h12345678); end
        vecs++; if (Overrun !== 1'b0) begin errs++; $display("FAIL ovr_not_yet got %b want 0", Overrun); end
        send_chunks(32'hCAFEF00D, 0, 7);
        vecs++; if (DataOut !== 32'h12345678) begin errs++; $display("FAIL ovr_hold got %h want %h", DataOut, 32'h12345678); end
        vecs++; if (Overrun !== 1'b1 || DataValid !== 1'b1) begin errs++; $display("FAIL ovr_flag got ovr=%b vld=%b want 1/1", Overrun, DataValid); end
        DataReady = 1'b1; ClearStatus = 1'b1;
        idle(1);
        ClearStatus = 1'b0;
        vecs++; if (DataValid !== 1'b0 || Overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear got vld=%b ovr=%b want 0/0", DataValid, Overrun); end
    endtask

    task automatic test_back_to_back;
        DataReady = 1'b0;
        send_chunks(32'h11111111, 0, 7);
        send_chunks(32'h22222222, 0, 6);
        vecs++; if (DataOut !== 32'h11111111 || DataValid !== 1'b1) begin errs++; $display("FAIL b2b_held got %b/%h want 1/%h", DataValid, DataOut, 32'h11111111); end
        DataReady = 1'b1;
        chunk(4'h2, 1'b0);
        vecs++; if (DataOut !== 32'h22222222) begin errs++; $display("FAIL b2b_data got %h want %h", DataOut, 32'h22222222); end
        vecs++; if (DataValid !== 1'b1 || Overrun !== 1'b0) begin errs++; $display("FAIL b2b_flags got vld=%b ovr=%b want 1/0", DataValid, Overrun); end
        idle(1);
        vecs++; if (DataValid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b want 0", DataValid); end
    endtask

    task automatic test_framing;
        DataReady = 1'b1;
        chunk(4'h5, 1'b0);
        vecs++; if (FrameError !== 1'b1 || RxBusy !== 1'b0 || DataValid !== 1'b0) begin errs++; $display("FAIL stray got fe=%b busy=%b vld=%b want 1/0/0", FrameError, RxBusy, DataValid); end
        idle(1);
        vecs++; if (FrameError !== 1'b0) begin errs++; $display("FAIL stray_pulse got %b want 0", FrameError); end
        chunk(4'hA, 1'b1); chunk(4'hB, 1'b0); chunk(4'hC, 1'b0);
        vecs++; if (FrameError !== 1'b0) begin errs++; $display("FAIL restart_pre got %b want 0", FrameError); end
        chunk(4'h8, 1'b1);
        vecs++; if (FrameError !== 1'b1 || RxBusy !== 1'b1) begin errs++; $display("FAIL restart_err got fe=%b busy=%b want 1/1", FrameError, RxBusy); end
        send_chunks(32'h87654321, 1, 7);
        vecs++; if (DataOut !== 32'h87654321 || DataValid !== 1'b1) begin errs++; $display("FAIL restart_word got %b/%h want 1/%h", DataValid, DataOut, 32'h87654321); end
        vecs++; if (FrameError !== 1'b0 || Overrun !== 1'b0) begin errs++; $display("FAIL restart_flags got fe=%b ovr=%b want 0/0", FrameError, Overrun); end
        idle(1);
    endtask

    task automatic test_async_reset;
        DataReady = 1'b0;
        send_chunks(32'h5A5A5A5A, 0, 7);
        send_chunks(32'h0BADF00D, 0, 4);
        #3 ResetN = 1'b0;
        #1;
        vecs++; if (DataOut !== 32'h0) begin errs++; $display("FAIL arst_data got %h want %h", DataOut, 32'h0); end
        vecs++; if ({DataValid, RxBusy, Overrun, FrameError} !== 4'b0000) begin errs++; $display("FAIL arst_flags got %b want 0000", {DataValid, RxBusy, Overrun, FrameError}); end
        #1 ResetN = 1'b1;
        DataReady = 1'b1;
        send_chunks(32'h0F1E2D3C, 0, 7);
        vecs++; if (DataOut !== 32'h0F1E2D3C || DataValid !== 1'b1 || FrameError !== 1'b0) begin errs++; $display("FAIL arst_after got %b/%h fe=%b want 1/%h fe=0", DataValid, DataOut, FrameError, 32'h0F1E2D3C); end
        idle(1);
    endtask

    task automatic test_gap;
        DataReady = 1'b1;
`ifdef RX_TIMEOUT_EN
        send_chunks(32'h13579BDF, 0, 2);
        idle(15);
        vecs++; if (RxBusy !== 1'b1 || FrameError !== 1'b0) begin errs++; $display("FAIL tmo_early got busy=%b fe=%b want 1/0", RxBusy, FrameError); end
        idle(1);
        vecs++; if (RxBusy !== 1'b0 || FrameError !== 1'b1) begin errs++; $display("FAIL tmo_fire got busy=%b fe=%b want 0/1", RxBusy, FrameError); end
        idle(1);
        send_chunks(32'h13579BDF, 0, 2);
        idle(15);
        send_chunks(32'h13579BDF, 3, 7);
        vecs++; if (DataOut !== 32'h13579BDF || DataValid !== 1'b1 || FrameError !== 1'b0) begin errs++; $display("FAIL tmo_word got %b/%h fe=%b want 1/%h fe=0", DataValid, DataOut, FrameError, 32'h13579BDF); end
`else
        send_chunks(32'h13579BDF, 0, 2);
        idle(20);
        vecs++; if (RxBusy !== 1'b1 || FrameError !== 1'b0) begin errs++; $display("FAIL gap_wait got busy=%b fe=%b want 1/0", RxBusy, FrameError); end
        send_chunks(32'h13579BDF, 3, 7);
        vecs++; if (DataOut !== 32'h13579BDF || DataValid !== 1'b1 || FrameError !== 1'b0) begin errs++; $display("FAIL gap_word got %b/%h fe=%b want 1/%h fe=0", DataValid, DataOut, FrameError, 32'h13579BDF); end
`endif
        idle(1);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_overrun;
        test_back_to_back;
        test_framing;
        test_async_reset;
        test_gap;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
